// File: rtl/exp_pkg.sv
// -----------------------------------------------------------------------------
// exp_pkg
// Shared constants and types for the shift-and-add e^x sequencer.
//   - Q-format widths: argument/residual Q4.11 (15 bit), result Q15.11 (26 bit)
//   - X_MAX: largest argument whose e^x fits in Q15.11 (15*ln2 in Q4.11)
//   - ONE_Q11: 1.0 in Q15.11
//   - default step-index bounds for the integer and fractional phases
//   - sequencer state enum
// Configuration macro: EXP_RESID_CORR_EN adds the residual-correction state.
// -----------------------------------------------------------------------------
package exp_pkg;

    localparam int unsigned X_W    = 15;
    localparam int unsigned Y_W    = 26;
    localparam int unsigned FRAC_W = 11;
    localparam int unsigned I_W    = 5;

    localparam logic [X_W-1:0] X_MAX   = 15'd21293;
    localparam logic [Y_W-1:0] ONE_Q11 = 26'h800;
    localparam logic [Y_W-1:0] Y_SAT   = '1;

    localparam int unsigned INT_I_MAX_DEF  = 14;
    localparam int unsigned FRAC_I_MAX_DEF = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_EVAL,
`ifdef EXP_RESID_CORR_EN
        S_CORR,
`endif
        S_DONE
    } state_e;

endpackage

// File: rtl/exp_mul_q11.sv
// -----------------------------------------------------------------------------
// exp_mul_q11
// Combinational Q15.11 x Q15.11 multiply: full 52-bit product, result is
// product bits [36:11] (truncated); any set bit in [51:37] saturates.
// Ports:
//   a_i   in  26  multiplicand, Q15.11
//   b_i   in  26  multiplier, Q15.11
//   p_o   out 26  truncated/saturated product, Q15.11
//   sat_o out 1   high when the product did not fit
// -----------------------------------------------------------------------------
module exp_mul_q11
    import exp_pkg::*;
(
    input  logic [Y_W-1:0] a_i,
    input  logic [Y_W-1:0] b_i,
    output logic [Y_W-1:0] p_o,
    output logic           sat_o
);

    // Product already shifted right by the fraction width; the discarded
    // low bits never need to exist as a signal.
    logic [2*Y_W-FRAC_W-1:0] prod_sh;

    always_comb begin
        prod_sh = (2*Y_W-FRAC_W)'(((2*Y_W)'(a_i) * (2*Y_W)'(b_i)) >> FRAC_W);
        sat_o   = |prod_sh[2*Y_W-FRAC_W-1:Y_W];
        p_o     = sat_o ? Y_SAT : prod_sh[Y_W-1:0];
    end

endmodule

// File: rtl/exp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// exp_seq_ctrl
// Iteration sequencer for the shift-and-add e^x engine. Scans integer steps
// (x2^i, i = INT_I_MAX downto 1, at most one taken) then fractional steps
// (x(1+2^-i), i = 1..FRAC_I_MAX), using the registered mul_gen results one
// cycle after each issue.
// Configuration macro: EXP_RESID_CORR_EN -- adds a CORR state applying
// y += (y*r) >> 11 with the final residual (one extra cycle of latency).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, x_in       request and Q4.11 argument (sampled only in IDLE)
//   busy, done        busy in ISSUE/EVAL/CORR; one-cycle done pulse
//   y_out, ovf        Q15.11 result and saturation flag
//   i, data,
//   int_or_fra        step issued to mul_gen (1 = integer step)
//   data_mul,
//   data_sub          mul_gen factor and residual minus ln(factor)
// -----------------------------------------------------------------------------
module exp_seq_ctrl
    import exp_pkg::*;
#(
    parameter int unsigned INT_I_MAX  = INT_I_MAX_DEF,
    parameter int unsigned FRAC_I_MAX = FRAC_I_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [X_W-1:0] x_in,
    output logic           busy,
    output logic           done,
    output logic [Y_W-1:0] y_out,
    output logic           ovf,
    output logic [I_W-1:0] i,
    output logic [X_W-1:0] data,
    output logic           int_or_fra,
    input  logic [Y_W-1:0] data_mul,
    input  logic [X_W-1:0] data_sub
);

    localparam logic [I_W-1:0] I_FIRST = I_W'(INT_I_MAX);
    localparam logic [I_W-1:0] I_LAST  = I_W'(FRAC_I_MAX);
    localparam logic [I_W-1:0] I_ONE   = I_W'(1);

    state_e         state_q;
    logic           busy_q;
    logic           done_q;
    logic [Y_W-1:0] y_out_q;
    logic           ovf_q;
    logic [I_W-1:0] i_q;
    logic [X_W-1:0] r_q;
    logic           int_q;
    logic [Y_W-1:0] y_q;

    logic [Y_W-1:0] mul_b;
    logic [Y_W-1:0] mul_p;
    logic           mul_sat;
    logic           accept;

`ifdef EXP_RESID_CORR_EN
    logic [Y_W:0] corr_sum;

    // The single multiplier is shared: mul_gen factor in EVAL, residual in CORR.
    always_comb begin
        mul_b    = (state_q == S_CORR) ? Y_W'(r_q) : data_mul;
        corr_sum = {1'b0, y_q} + {1'b0, mul_p};
    end
`else
    always_comb mul_b = data_mul;
`endif

    // Every ln(factor) is non-zero, so a wrapped subtraction never reads below r.
    always_comb accept = (data_sub < r_q);

    exp_mul_q11 u_mul (
        .a_i  (y_q),
        .b_i  (mul_b),
        .p_o  (mul_p),
        .sat_o(mul_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_out_q <= '0;
            ovf_q   <= 1'b0;
            i_q     <= '0;
            r_q     <= '0;
            int_q   <= 1'b0;
            y_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        r_q   <= x_in;
                        ovf_q <= 1'b0;
                        if (x_in > X_MAX) begin
                            y_q     <= Y_SAT;
                            y_out_q <= Y_SAT;
                            ovf_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            y_q     <= ONE_Q11;
                            int_q   <= 1'b1;
                            i_q     <= I_FIRST;
                            busy_q  <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_EVAL;
                end
                S_EVAL: begin
                    if (accept) begin
                        r_q <= data_sub;
                        y_q <= mul_p;
                        if (mul_sat) ovf_q <= 1'b1;
                    end
                    if (int_q) begin
                        if (accept || i_q == I_ONE) begin
                            int_q <= 1'b0;
                            i_q   <= I_ONE;
                        end else begin
                            i_q <= i_q - I_ONE;
                        end
                        state_q <= S_ISSUE;
                    end else if (i_q < I_LAST) begin
                        i_q     <= i_q + I_ONE;
                        state_q <= S_ISSUE;
                    end else begin
`ifdef EXP_RESID_CORR_EN
                        state_q <= S_CORR;
`else
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
`endif
                    end
                end
`ifdef EXP_RESID_CORR_EN
                S_CORR: begin
                    if (mul_sat || corr_sum[Y_W]) begin
                        y_q   <= Y_SAT;
                        ovf_q <= 1'b1;
                    end else begin
                        y_q <= corr_sum[Y_W-1:0];
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
`endif
                S_DONE: begin
                    done_q  <= 1'b1;
                    y_out_q <= y_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign y_out      = y_out_q;
    assign ovf        = ovf_q;
    assign i          = i_q;
    assign data       = r_q;
    assign int_or_fra = int_q;

endmodule

// File: tb/tb_exp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exp_seq_ctrl
// Scoreboard bench for exp_seq_ctrl with a behavioural mul_gen stage and a
// reference e^x model built from ln tables (floor of ln(factor) in Q4.11).
// -----------------------------------------------------------------------------
module tb_exp_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [14:0] x_in = '0;
    logic        busy, done, ovf, int_or_fra;
    logic [25:0] y_out;
    logic [4:0]  i;
    logic [14:0] data;
    logic [25:0] data_mul = '0;
    logic [14:0] data_sub = '0;

    exp_seq_ctrl #(.INT_I_MAX(14), .FRAC_I_MAX(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
        .busy(busy), .done(done), .y_out(y_out), .ovf(ovf),
        .i(i), .data(data), .int_or_fra(int_or_fra),
        .data_mul(data_mul), .data_sub(data_sub)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    int ln_int [32];
    int ln_frac[32];

    // Behavioural mul_gen: one registered stage.
    always @(posedge clk) begin
        if (int_or_fra) begin
            data_mul <= 26'(64'(1) << (i + 11));
            data_sub <= data - 15'(ln_int[i]);
        end else begin
            data_mul <= 26'd2048 + (26'd2048 >> i);
            data_sub <= data - 15'(ln_frac[i]);
        end
    end

    typedef struct {
        logic [25:0] y;
        bit          ov;
        int          at;
        int          busy_n;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic longint sat26(input longint v, inout bit ov);
        if (v > 64'd67108863) begin
            ov = 1'b1;
            return 64'd67108863;
        end
        return v;
    endfunction

    // e^x: greedy integer power of two, then each (1+2^-k) factor that fits.
    function automatic void ref_model(input logic [14:0] x, output logic [25:0] y,
                                      output bit ov, output int lat);
        longint yy;
        int     r;
        int     nint;
        ov = 1'b0;
        if (int'(x) > 21293) begin
            y   = '1;
            ov  = 1'b1;
            lat = 1;
            return;
        end
        r    = int'(x);
        yy   = 2048;
        nint = 0;
        for (int k = 14; k >= 1; k--) begin
            nint++;
            if (ln_int[k] <= r) begin
                r  -= ln_int[k];
                yy = sat26(yy * (longint'(1) << k), ov);
                break;
            end
        end
        for (int k = 1; k <= 10; k++) begin
            if (ln_frac[k] <= r) begin
                r  -= ln_frac[k];
                yy = sat26((yy * (2048 + (2048 >> k))) / 2048, ov);
            end
        end
        lat = 2 * (nint + 10) + 1;
`ifdef EXP_RESID_CORR_EN
        yy  = sat26(yy + (yy * r) / 2048, ov);
        lat = lat + 1;
`endif
        y = 26'(yy);
    endfunction

    // Monitor: pops an expectation on each done pulse.
    int busy_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("y_out", y_out, e.y);
                check("ovf", ovf, e.ov);
                check("done_cycle", cyc, e.at);
                check("busy_cycles", busy_cnt, e.busy_n);
            end
            busy_cnt = 0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_y_out"}, y_out, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_i"}, i, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_int_or_fra"}, int_or_fra, 0);
    endtask

    // One transaction. pulse_at: edge (relative to acceptance) sampling a
    // second start, -1 for none. rst_at: edge sampling reset, -1 for none.
    task automatic run(input logic [14:0] x, input int pulse_at, input int rst_at);
        exp_t e;
        int   lat;
        int   acc;
        int   n;
        ref_model(x, e.y, e.ov, lat);
        start    = 1'b1;
        x_in     = x;
        acc      = cyc + 1;
        e.at     = acc + lat;
        e.busy_n = lat - 1;
        if (rst_at < 0) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        x_in  = 15'($urandom);
        n = 0;
        while (!done) begin
            start = (pulse_at >= 0 && cyc == acc + pulse_at - 1);
            if (rst_at >= 0 && cyc == acc + rst_at - 1) begin
                rst_n = 1'b0;
                @(negedge clk);
                check_reset_outputs("midrst");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (n > 200) begin
                check("done_timeout", n, lat);
                return;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [14:0] xr;
        for (int k = 0; k < 32; k++) begin
            ln_int[k]  = $rtoi(real'(k) * $ln(2.0) * 2048.0);
            ln_frac[k] = $rtoi($ln(1.0 + 1.0 / real'(64'(1) << k)) * 2048.0);
        end
        ln_frac[0] = ln_int[1];

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(15'd0,     -1, -1);
        run(15'd1419,  -1, -1);
        run(15'd19873, -1, -1);
        run(15'd21294, -1, -1);
        run(15'd21293, -1, -1);
        run(15'd32767, -1, -1);
        run(15'd5000,  10, -1);
        run(15'd12345, -1, 15);
        run(15'd1419,  -1, -1);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 7) == 0) xr = 15'($urandom_range(21294, 32767));
            else                           xr = 15'($urandom_range(0, 21293));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(xr, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : -1, -1);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exp_seq_ctrl.md
# exp_seq_ctrl

- Iteration sequencer for the shift-and-add e^x engine.
- Takes an unsigned Q4.11 argument, issues `(i, data, int_or_fra)` steps to the downstream `mul_gen` stage, and consumes its registered `data_mul` and `data_sub` one cycle later.
- On accepted steps, keeps the residual and multiplies a running Q15.11 result by `data_mul`.
- Returns e^x with a start/done handshake.

## Interface
Parameters:
- `INT_I_MAX`, default 14: first (largest) integer step index.
- `FRAC_I_MAX`, default 10: last fractional step index.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low; clock clk.
- `start` in 1: request; sampled only in IDLE.
- `x_in` in 15: argument, unsigned Q4.11.
- `busy` out 1: high in ISSUE/EVAL/CORR.
- `done` out 1: one-cycle pulse; `y_out` is valid from this cycle.
- `y_out` out 26: e^x, unsigned Q15.11; held until the next accepted start.
- `ovf` out 1: saturation flag, valid with `done`.
- `i` out 5: step index to `mul_gen`.
- `data` out 15: current residual to `mul_gen`.
- `int_or_fra` out 1: step type to `mul_gen`; 1 = integer (×2^i), 0 = fractional (×(1+2^-i)).
- `data_mul` in 26: factor from `mul_gen`, Q15.11.
- `data_sub` in 15: `data - ln(factor)` from `mul_gen`, modulo 2^15.

## Operation
States:
- IDLE
- ISSUE
- EVAL
- CORR (only with the macro)
- DONE

IDLE + start:
- Latch `x_in`; clear `ovf`.
- If `x_in > X_MAX` (15'd21293 = 15·ln2): `y_out <= 26'h3FFFFFF`, `ovf <= 1`, go to DONE.
- Otherwise: residual r = `x_in`, y = `ONE_Q11` (26'h800), phase = INT, i = `INT_I_MAX`, go to ISSUE.

ISSUE:
- Drive `i`, `data = r`, `int_or_fra = (phase == INT)`.
- Go to EVAL.

EVAL (`mul_gen` outputs now reflect the issued step):
- Accept iff `data_sub < r`. Every issued sub is > 0, so a wrapped difference reads ≥ r.
- On accept: `r <= data_sub`; `y <= mul_q11(y, data_mul)`.
- INT phase:
  - Accept, or i == 1: switch to FRAC with i = 1.
  - Otherwise: i−1.
- FRAC phase:
  - i < `FRAC_I_MAX`: i+1, back to ISSUE.
  - Else: go to CORR (macro) or DONE.

Integer phase behaviour:
- Greedy descending scan; at most one integer step is taken.
- Each fractional index is tried exactly once.

mul_q11:
- 26×26 → 52-bit product, keep bits [36:11] (truncate).
- If bits [51:37] ≠ 0, saturate to 26'h3FFFFFF and set `ovf`. Unreachable for x ≤ X_MAX; required anyway.

DONE:
- Pulse `done`, present `y_out`, return to IDLE.

Other rules:
- `start` outside IDLE is ignored, including in the DONE cycle.
- Residual r is not used after the FRAC phase unless the macro is set.

## Timing
- Reset values: `busy` 0, `done` 0, `y_out` 0, `ovf` 0, `i` 0, `data` 0, `int_or_fra` 0; state IDLE.
- Reset mid-operation aborts the computation with no `done` pulse.
- Cycle 0 is the edge where start is accepted.
- Each step takes 2 cycles (ISSUE, EVAL), matching the 1-cycle `mul_gen` latency.
- Integer phase: k+1 steps, with k = 0 if step 14 accepts, up to 13 if none accept. Then 10 fractional steps.
- `done` arrives at cycle 2·(k+11)+1:
  - worst case 49 (no integer accept at i ≥ 2);
  - best case 23.
- Add +1 cycle with CORR.
- Overflow path: `done` at cycle 1.
- `i`, `data`, `int_or_fra` are held stable through ISSUE and EVAL.

## Configuration
`EXP_RESID_CORR_EN`:
- Defined: after the FRAC phase, CORR performs `y <= y + ((y·r) >> 11)` (first-order e^r ≈ 1+r), saturating per mul_q11. Adds 1 cycle of latency.
- Undefined: CORR does not exist, the final residual is discarded, and latencies are as above.

## Structure
Package `exp_pkg` holds:
- `X_MAX`
- `ONE_Q11`
- `INT_I_MAX` and `FRAC_I_MAX` defaults
- the Q-format width constants
- the state enum

Sub-module: `exp_mul_q11`, a combinational 26×26 multiply with truncate-and-saturate. It is used by EVAL and by CORR.

## Test plan
- `x_in` = 0 → all steps rejected; `y_out` = 26'h800, `ovf` = 0, `done` at cycle 49.
- `x_in` = 1419 (ln2) → integer i=1 accepted (residual 0), all fractional steps rejected; `y_out` = 26'h1000, `done` at cycle 49.
- `x_in` = 19873 (14·ln2 table value) → i=14 accepted at the first EVAL; `y_out` = 26'h2000000, `done` at cycle 23.
- `x_in` = 21294 → `y_out` = 26'h3FFFFFF, `ovf` = 1, `done` at cycle 1, `busy` never high.
- `start` pulsed again at cycle 10 → ignored, the result matches the first argument.
- `rst_n` low at cycle 15 → all outputs 0 next cycle; a new start then runs normally.
